// File: rtl/cache_pkg.sv
// Shared cache-line definitions.
// Holds the line geometry constants, the line-fill FSM state encoding and a
// helper that extracts one byte lane from a packed 8*LINE_BYTES line vector.
package cache_pkg;

  localparam int LINE_BYTES = 32;
  localparam int OFF_W      = 5;   // log2(LINE_BYTES)
  localparam int WAY_W      = 2;   // 4 ways
  localparam int LINE_W     = 8 * LINE_BYTES;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } fill_state_t;

  // Byte k of a packed line lives in bits [8k+7:8k].
  function automatic logic [7:0] line_byte(input logic [LINE_W-1:0] line,
                                           input logic [OFF_W-1:0]  idx);
    return line[8*idx +: 8];
  endfunction

endpackage

// File: rtl/byte_demux_1to32.sv
// Offset-to-lane one-hot byte-enable decoder (write-side inverse of the 32:1
// byte read mux).
// Ports:
//   en      - qualifies the decode; all lanes low when en=0
//   sel     - byte offset within the line
//   lane_en - one-hot lane enable, bit k set when en && sel==k
module byte_demux_1to32
  import cache_pkg::*;
(
  input  logic                  en,
  input  logic [OFF_W-1:0]      sel,
  output logic [LINE_BYTES-1:0] lane_en
);

  for (genvar gi = 0; gi < LINE_BYTES; gi++) begin : g_lane
    assign lane_en[gi] = en && (sel == OFF_W'(gi));
  end

endmodule

// File: rtl/line_fill_demux_8b.sv
// Cache line refill assembler.
// Collects a 32-byte line from a byte-serial refill stream that starts at the
// critical byte and wraps, merges store bytes that arrive during the fill,
// then presents the whole line to the data array with a one-cycle write pulse.
// Ports:
//   clk, rst                       - clock, asynchronous active-high reset
//   fill_start, fill_way, fill_off - fill request, target way, critical offset
//   mem_valid, mem_data, mem_ready - refill byte stream handshake
//   st_valid, st_off, st_data      - store byte to merge during the fill
//   crit_valid, crit_data          - one-cycle critical-byte forward
//   line_we, line_way, line_out    - line write strobe, way and line data
//   busy                           - fill or commit in progress
module line_fill_demux_8b
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fill_start,
  input  logic [WAY_W-1:0]      fill_way,
  input  logic [OFF_W-1:0]      fill_off,
  input  logic                  mem_valid,
  input  logic [7:0]            mem_data,
  output logic                  mem_ready,
  input  logic                  st_valid,
  input  logic [OFF_W-1:0]      st_off,
  input  logic [7:0]            st_data,
  output logic                  crit_valid,
  output logic [7:0]            crit_data,
  output logic                  line_we,
  output logic [WAY_W-1:0]      line_way,
  output logic [LINE_W-1:0]     line_out,
  output logic                  busy
);

  fill_state_t           state, state_next;
  logic [WAY_W-1:0]      way_q;
  logic [OFF_W-1:0]      ptr;
  logic [OFF_W-1:0]      beat_cnt;
  logic [LINE_BYTES-1:0] mask;
  logic [LINE_BYTES-1:0] st_lane;
  logic [LINE_BYTES-1:0] rf_lane;
  logic                  in_fill;
  logic                  accept;
  logic                  first_beat;
  logic                  last_beat;
  logic                  start;
  logic [7:0]            crit_next;

  assign in_fill    = (state == FILL);
  assign start      = (state == IDLE) && fill_start;
  assign accept     = mem_valid && mem_ready;
  assign first_beat = accept && (beat_cnt == '0);
  assign last_beat  = accept && (beat_cnt == OFF_W'(LINE_BYTES - 1));

  // Next state and state-decoded outputs.
  always_comb begin
    state_next = state;
    mem_ready  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (fill_start) state_next = FILL;
      end
      FILL: begin
        mem_ready = 1'b1;
        busy      = 1'b1;
        if (last_beat) state_next = COMMIT;
      end
      COMMIT: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  byte_demux_1to32 u_st_demux (
    .en      (st_valid && in_fill),
    .sel     (st_off),
    .lane_en (st_lane)
  );

  byte_demux_1to32 u_rf_demux (
    .en      (accept),
    .sel     (ptr),
    .lane_en (rf_lane)
  );

  // Per-lane write priority: a store this cycle, else a refill beat unless a
  // store already claimed the lane earlier in the fill.
  for (genvar gi = 0; gi < LINE_BYTES; gi++) begin : g_buf
    logic [7:0] lane_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                           lane_q <= '0;
      else if (st_lane[gi])              lane_q <= st_data;
      else if (rf_lane[gi] && !mask[gi]) lane_q <= mem_data;
    end
    assign line_out[8*gi +: 8] = lane_q;
  end

  // The critical byte forward must report what the line will actually hold,
  // so a store (same cycle or earlier) to that offset takes precedence.
  always_comb begin
    if (st_lane[ptr])   crit_next = st_data;
    else if (mask[ptr]) crit_next = line_byte(line_out, ptr);
    else                crit_next = mem_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      way_q      <= '0;
      ptr        <= '0;
      beat_cnt   <= '0;
      mask       <= '0;
      crit_valid <= 1'b0;
      crit_data  <= '0;
      line_we    <= 1'b0;
      line_way   <= '0;
    end else begin
      crit_valid <= first_beat;
      line_we    <= last_beat;
      if (first_beat) crit_data <= crit_next;
      if (last_beat)  line_way  <= way_q;
      if (start) begin
        way_q    <= fill_way;
        ptr      <= fill_off;
        beat_cnt <= '0;
        mask     <= '0;
      end else if (in_fill) begin
        mask <= mask | st_lane | rf_lane;
        if (accept) begin
          ptr      <= ptr + OFF_W'(1);
          beat_cnt <= beat_cnt + OFF_W'(1);
        end
      end
    end
  end

endmodule
